// File: rtl/otter_iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO, a baud-timed
// serializer drains it onto TX, and a level interrupt flags "all data sent".
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | line high, waiting for enable & FIFO not empty
// START | driving the start bit (low)
// DATA  | shifting out 8 data bits, LSB first
// STOP  | driving the stop bit (high)
module otter_iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        TX_IRQ
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BC_W  = $clog2(CLKS_PER_BIT);

    localparam logic [BC_W-1:0]  BC_LOAD     = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      ADDR_STATUS = BASE_ADDR + 32'd4;
    localparam logic [31:0]      ADDR_CTRL   = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t           state;
    logic [BC_W-1:0]  bc;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             enable;

    logic sel_data, sel_status, sel_ctrl;
    logic wr_data, wr_status, wr_ctrl;
    logic fifo_empty, fifo_full;
    logic bit_end, push, pop, idle_next, busy;
    logic [7:0] head;

    logic unused_bits;
    assign unused_bits = ^{IOBUS_OUT[31:8], IOBUS_ADDR[1:0]};

    always_comb begin
        sel_data   = (IOBUS_ADDR[31:2] == BASE_ADDR[31:2]);
        sel_status = (IOBUS_ADDR[31:2] == ADDR_STATUS[31:2]);
        sel_ctrl   = (IOBUS_ADDR[31:2] == ADDR_CTRL[31:2]);
        wr_data    = IOBUS_WR & sel_data;
        wr_status  = IOBUS_WR & sel_status;
        wr_ctrl    = IOBUS_WR & sel_ctrl;

        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_FULL);
        bit_end    = (bc == '0);
        busy       = (state != ST_IDLE);
        head       = mem[rd_ptr];

        // All decisions use pre-edge state, so a push into an empty FIFO
        // cannot be popped on the same edge and a full FIFO always drops.
        push      = wr_data & !fifo_full;
        pop       = enable & !fifo_empty &
                    ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
        idle_next = ((state == ST_IDLE) | ((state == ST_STOP) & bit_end)) & !pop;
    end

    always_comb begin
        IOBUS_IN = 32'h0;
        if (sel_status)
            IOBUS_IN = {16'h0, 8'(count), 4'h0, overflow, busy, fifo_full, fifo_empty};
        else if (sel_ctrl)
            IOBUS_IN = {31'h0, enable};
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= IOBUS_OUT[7:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enable   <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (wr_data & fifo_full)
                overflow <= 1'b1;
            else if (wr_status & IOBUS_OUT[3])
                overflow <= 1'b0;
            if (wr_ctrl)
                enable <= IOBUS_OUT[0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            bc      <= BC_LOAD;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            TX      <= 1'b1;
            TX_IRQ  <= 1'b1;
        end else begin
            TX_IRQ <= enable & fifo_empty & idle_next;
            case (state)
                ST_IDLE: begin
                    TX <= 1'b1;
                    if (pop) begin
                        shift <= head;
                        TX    <= 1'b0;
                        bc    <= BC_LOAD;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        TX      <= shift[0];
                        bit_idx <= 3'd0;
                        bc      <= BC_LOAD;
                        state   <= ST_DATA;
                    end else begin
                        bc <= bc - BC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bc <= BC_LOAD;
                        if (bit_idx == 3'd7) begin
                            TX    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            TX      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bc <= bc - BC_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        bc <= BC_LOAD;
                        // Chain straight into the next start bit with no idle gap.
                        if (pop) begin
                            shift <= head;
                            TX    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            TX    <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        bc <= bc - BC_W'(1);
                    end
                end
                default: begin
                    TX    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Scoreboard bench for otter_iobus_uart_tx: stimulus queues expected bytes,
// a serial-line monitor decodes frames from TX and checks them against the queue.
module tb_otter_iobus_uart_tx;

    localparam logic [31:0] BASE   = 32'h1100_0100;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;

    logic        CLK        = 1'b0;
    logic        RESET      = 1'b1;
    logic [31:0] IOBUS_ADDR = 32'h0;
    logic [31:0] IOBUS_OUT  = 32'h0;
    logic        IOBUS_WR   = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        TX;
    logic        TX_IRQ;

    int n_cmp     = 0;
    int n_err     = 0;
    int rst_count = 0;
    logic [7:0] exp_q [$];

    otter_iobus_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .IOBUS_IN  (IOBUS_IN),
        .TX        (TX),
        .TX_IRQ    (TX_IRQ)
    );

    always #5 CLK = ~CLK;

    always @(posedge RESET) rst_count++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge CLK);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic send_byte(input logic [31:0] a, input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(a, {24'h0, b});
    endtask

    task automatic chk_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        IOBUS_ADDR = a;
        #1;
        chk(name, IOBUS_IN, exp);
    endtask

    // Cycle-exact waveform and status check over nfr frames, starting on the
    // cycle that holds the first start bit.
    task automatic check_frames(input logic [7:0] b0, input logic [7:0] b1, input int nfr,
                                input int c0, input int c1);
        IOBUS_ADDR = A_STAT;
        for (int c = 0; c < 40 * nfr; c++) begin
            int f;
            int p;
            logic [7:0] b;
            logic exp_bit;
            f = c / 40;
            p = (c % 40) / 4;
            b = (f == 0) ? b0 : b1;
            if (p == 0)      exp_bit = 1'b0;
            else if (p == 9) exp_bit = 1'b1;
            else             exp_bit = b[p-1];
            #1;
            chk("tx_bit", {31'h0, TX}, {31'h0, exp_bit});
            chk("busy", {31'h0, IOBUS_IN[2]}, 32'h1);
            chk("frame_count", {24'h0, IOBUS_IN[15:8]}, (f == 0) ? c0 : c1);
            chk("irq_in_frame", {31'h0, TX_IRQ}, 32'h0);
            @(negedge CLK);
        end
    endtask

    // Serial monitor: samples mid-bit, discards frames cut by a reset.
    initial begin
        logic [7:0] b;
        logic start_b, stop_b;
        int rc;
        forever begin
            @(negedge TX);
            if (RESET) continue;
            rc = rst_count;
            #25;
            start_b = TX;
            for (int i = 0; i < 8; i++) begin
                #40;
                b[i] = TX;
            end
            #40;
            stop_b = TX;
            if (rc != rst_count) continue;
            chk("start_bit", {31'h0, start_b}, 32'h0);
            chk("stop_bit", {31'h0, stop_b}, 32'h1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame: got %h want none", b);
            end else begin
                chk("frame_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int lowcnt;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Reset: disable first so the asynchronous restore of enable and IRQ is visible.
        bus_write(A_CTRL, 32'h0);
        chk_read("ctrl_cleared", A_CTRL, 32'h0);
        @(negedge CLK);
        chk("irq_disabled", {31'h0, TX_IRQ}, 32'h0);
        #2 RESET = 1'b1;
        #1;
        chk("reset_tx", {31'h0, TX}, 32'h1);
        chk("reset_irq", {31'h0, TX_IRQ}, 32'h1);
        @(negedge CLK);
        RESET = 1'b0;
        chk_read("reset_status", A_STAT, 32'h0000_0001);
        chk_read("reset_ctrl", A_CTRL, 32'h0000_0001);
        chk_read("data_reads_zero", A_DATA, 32'h0);
        @(negedge CLK);

        // Single byte: start bit begins one edge after the write edge.
        send_byte(A_DATA, 8'h55);
        #1;
        chk("latency_tx_high", {31'h0, TX}, 32'h1);
        @(negedge CLK);
        check_frames(8'h55, 8'h00, 1, 0, 0);
        #1;
        chk("single_idle_tx", {31'h0, TX}, 32'h1);
        chk("single_irq_back", {31'h0, TX_IRQ}, 32'h1);
        chk_read("single_status_idle", A_STAT, 32'h0000_0001);
        @(negedge CLK);

        // Back-to-back frames with no gap.
        send_byte(A_DATA, 8'hA5);
        send_byte(A_DATA, 8'h3C);
        check_frames(8'hA5, 8'h3C, 2, 1, 0);
        #1;
        chk("b2b_idle_tx", {31'h0, TX}, 32'h1);
        chk("b2b_irq_back", {31'h0, TX_IRQ}, 32'h1);
        chk_read("b2b_status_idle", A_STAT, 32'h0000_0001);
        @(negedge CLK);

        // Overflow: fill while disabled, ninth push dropped.
        bus_write(A_CTRL, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) send_byte(A_DATA, 8'(i));
            else        bus_write(A_DATA, 32'h9);
        end
        chk_read("ovf_status", A_STAT, 32'h0000_080A);
        chk("ovf_tx_idle", {31'h0, TX}, 32'h1);
        @(negedge CLK);
        bus_write(A_STAT, 32'h8);
        chk_read("ovf_w1c", A_STAT, 32'h0000_0802);
        @(negedge CLK);
        bus_write(A_CTRL, 32'h1);
        repeat (360) @(negedge CLK);
        chk_read("ovf_drained_status", A_STAT, 32'h0000_0001);
        chk("ovf_drained_irq", {31'h0, TX_IRQ}, 32'h1);
        chk("ovf_queue_drained", exp_q.size(), 32'h0);

        // Mid-frame reset during data bit 3 of 0x11 (bit value 0).
        send_byte(A_DATA, 8'h11);
        send_byte(A_DATA, 8'h22);
        send_byte(A_DATA, 8'h33);
        repeat (16) @(negedge CLK);
        #2;
        chk("pre_reset_tx_low", {31'h0, TX}, 32'h0);
        RESET = 1'b1;
        #1;
        chk("midreset_tx", {31'h0, TX}, 32'h1);
        chk("midreset_irq", {31'h0, TX_IRQ}, 32'h1);
        exp_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        chk_read("midreset_status", A_STAT, 32'h0000_0001);
        lowcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1) lowcnt++;
        end
        chk("no_frames_after_reset", lowcnt, 32'h0);

        // Decode: out-of-window writes ignored, unaligned DATA alias accepted.
        bus_write(BASE + 32'hC, 32'hFF);
        bus_write(BASE - 32'h4, 32'hFF);
        chk_read("decode_status", A_STAT, 32'h0000_0001);
        chk("decode_tx_high", {31'h0, TX}, 32'h1);
        chk_read("decode_read_plus_c", BASE + 32'hC, 32'h0);
        chk_read("decode_read_minus_4", BASE - 32'h4, 32'h0);
        @(negedge CLK);
        send_byte(BASE + 32'h2, 8'h5A);
        chk_read("alias_queued", A_STAT, 32'h0000_0100);
        repeat (60) @(negedge CLK);
        chk_read("alias_done_status", A_STAT, 32'h0000_0001);

        chk("final_queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/otter_iobus_uart_tx.md
# otter_iobus_uart_tx

Memory-mapped UART transmitter that responds to the OTTER MCU's IOBUS (`IOBUS_ADDR`/`IOBUS_OUT`/`IOBUS_WR` from the CPU, `IOBUS_IN` back to it). CPU stores push bytes into a TX FIFO. An 8N1 serializer drains the FIFO onto a single `TX` pin. Status and control registers are readable over the same bus, and a level interrupt flags "all data sent".

## Interface
- `BASE_ADDR`, default 32'h1100_0100: word-aligned base of the 3-register window.
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (≥2).
- `FIFO_DEPTH`, default 8: TX FIFO entries, power of 2, 2..128.
- `CLK`  in  1: single clock, rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `IOBUS_ADDR`  in  32: byte address from CPU memory stage.
- `IOBUS_OUT`  in  32: store data from CPU.
- `IOBUS_WR`  in  1: one-cycle write strobe.
- `IOBUS_IN`  out  32: read data to CPU, combinational from `IOBUS_ADDR` and current register state.
- `TX`  out  1: serial output, registered, idle high.
- `TX_IRQ`  out  1: level interrupt, registered.

## Operation
- Decode compares `IOBUS_ADDR[31:2]` to `(BASE_ADDR+off)[31:2]`; bits [1:0] ignored.
  - Unmapped address: writes ignored; `IOBUS_IN` = 0.
- **DATA (+0x0).** Write pushes `IOBUS_OUT[7:0]`. Read returns 0. Reads have no side effects on any register.
- **STATUS (+0x4).** Read fields:
  - bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
  - [15:8] FIFO count, zero-extended; other bits 0.
  - Write: `IOBUS_OUT[3]`=1 clears overflow (W1C); other bits ignored.
- **CTRL (+0x8).** bit0 enable; read returns {31'b0, enable}.
  - Clearing enable stops new frames from starting; a frame in progress completes.
- **Push when full.** Fullness is evaluated on pre-edge state. A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
- **Push when empty.** A push into an empty FIFO cannot be popped on the same edge.
- **Read ordering.** Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved (FIFO).
- **FSM states:** IDLE, START, DATA, STOP. Baud counter `bc` counts down from CLKS_PER_BIT-1; a bit ends when `bc`==0.
  - IDLE: when enable & !empty → pop head into the shift register, `TX`←0, `bc`←CLKS_PER_BIT-1, go to START.
  - START: at bit end → `TX`←shift[0], bit index←0, go to DATA.
  - DATA: at each bit end → shift right, send the next bit LSB-first. After bit 7 ends → `TX`←1, go to STOP.
  - STOP: at bit end, if enable & !empty → pop and go straight to START with `TX`←0 (no idle gap). Otherwise `TX`←1 and go to IDLE.
- **Interrupt.** `TX_IRQ` ← enable & empty & (next state == IDLE).
- **Reset values.**
  - `TX`=1, FSM=IDLE, FIFO empty, count=0, overflow=0, enable=1, `TX_IRQ`=1.
  - `IOBUS_IN` follows decode: STATUS reads 0x0000_0001 after reset.
  - A mid-frame reset forces `TX` high immediately (asynchronous) and discards FIFO contents.

## Timing
- Write to pop latency with an idle FSM and enable=1:
  - Push on edge N.
  - Pop and `TX` falling on edge N+1.
- Each bit occupies exactly CLKS_PER_BIT cycles; a frame is 10×CLKS_PER_BIT cycles (start, 8 data, stop).
- Back-to-back frames: the next start bit begins on the same edge the previous stop bit ends.
- Register effects (push, W1C, CTRL write) are visible on `IOBUS_IN` from the cycle after the `IOBUS_WR` edge.
- Busy drops, and `TX_IRQ` rises if the FIFO is empty, on the edge ending the last stop bit.
- No throughput limit on pushes: one per cycle until full.

## Test plan
Benches use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- **Reset.** Assert `RESET` asynchronously mid-cycle → `TX`=1, `TX_IRQ`=1, read BASE+4 = 0x0000_0001, read BASE+8 = 0x0000_0001.
- **Single byte.** Write 0x55 to BASE+0 → `TX` low 4 cycles starting one edge after the write, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - STATUS bit2=1 throughout the 40 cycles; `TX_IRQ`=0 during the frame, back to 1 afterwards.
- **Back-to-back.** Write 0xA5 then 0x3C on consecutive cycles → two frames totalling 80 cycles with no idle cycle between the first stop bit and the second start bit.
  - Decoded bytes are 0xA5 then 0x3C.
  - STATUS count reads 1 during frame 1 and 0 during frame 2.
- **Overflow.** Write 0 to CTRL, then write 0x01..0x09 to DATA → STATUS = 0x0000_080A (count 8, full, overflow).
  - Writing 0x8 to STATUS → 0x0000_0802.
  - Writing 1 to CTRL → bytes 0x01..0x08 transmitted in order; 0x09 is never sent.
- **Mid-frame reset.** Push 3 bytes, then assert `RESET` during DATA bit 3 → `TX`=1 immediately, STATUS=0x0000_0001 after release, and no further frames.
- **Decode.** Write 0xFF to BASE+0xC and to BASE-4 → FIFO count stays 0 and `TX` stays high; reads of those addresses return 0.
  - Write to BASE+2 (unaligned alias of DATA) → byte queued.
